// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding and control-bit layout.
package pipe_pkg;

  // How many of the two stage slots currently hold a live instruction.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Bit positions inside the control vector carried down the pipe.
  localparam int CTRL_DM_WE    = 0;
  localparam int CTRL_RF_D_SEL = 1;
  localparam int CTRL_NEXT_PC  = 2;

  // Write-enable bits that must never leave the stage on a bubble.
  localparam logic [3:0] DEFAULT_WE_MASK = 4'(1 << CTRL_DM_WE);

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increment requests; hold once every bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer, flush and a
// saturating stall counter.
//
// Handshake: a transfer happens on an input (or output) side exactly on a
// rising edge where the corresponding valid and ready are both high; valid
// and payload, once raised, are held until that transfer. in_ready depends
// only on registers and rst, never on out_ready.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 16,
  parameter int                CTRL_W      = 4,
  parameter logic [CTRL_W-1:0] WE_MASK     = CTRL_W'(DEFAULT_WE_MASK),
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_alu_res,
  input  logic [DATA_W-1:0]      in_store_data,
  input  logic [ADDR_W-1:0]      in_dm_addr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_alu_res,
  output logic [DATA_W-1:0]      out_store_data,
  output logic [ADDR_W-1:0]      out_dm_addr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] store_data;
    logic [ADDR_W-1:0] dm_addr;
  } payload_t;

  // Occupancy state; kept as a named signal so checkers can bind to it.
  occ_e     state;
  payload_t main_q;
  payload_t skid_q;
  payload_t in_pl;
  logic     main_valid;
  logic     skid_valid;
  logic     accept;
  logic     drain;

  assign in_pl      = '{ctrl: in_ctrl, alu_res: in_alu_res,
                        store_data: in_store_data, dm_addr: in_dm_addr};
  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign in_ready   = !skid_valid && !rst;
  assign out_valid  = main_valid;
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;

  // Occupancy FSM and slot payloads; flush only clears occupancy, the
  // payload registers keep whatever they last held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_pl;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= in_pl;
          end else if (accept) begin
            skid_q <= in_pl;
            state  <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can move things.
          if (drain) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Write enables are suppressed on a bubble so stale control cannot fire.
  assign out_ctrl       = main_q.ctrl & ~(WE_MASK & {CTRL_W{!out_valid}});
  assign out_alu_res    = main_q.alu_res;
  assign out_store_data = main_q.store_data;
  assign out_dm_addr    = main_q.dm_addr;

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue model.
module tb_ex_mem_skid_stage;

  localparam int EW = 4 + 32 + 32 + 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_alu_res;
  logic [31:0] in_store_data;
  logic [15:0] in_dm_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [31:0] out_alu_res;
  logic [31:0] out_store_data;
  logic [15:0] out_dm_addr;
  logic [15:0] stall_cnt;

  // Narrow-counter copy sharing all inputs; only its counter is examined.
  logic        s_in_ready;
  logic        s_out_valid;
  logic [3:0]  s_out_ctrl;
  logic [31:0] s_out_alu_res;
  logic [31:0] s_out_store_data;
  logic [15:0] s_out_dm_addr;
  logic [2:0]  s_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_dm_addr(in_dm_addr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu_res(out_alu_res),
    .out_store_data(out_store_data), .out_dm_addr(out_dm_addr),
    .stall_cnt(stall_cnt)
  );

  ex_mem_skid_stage #(.STALL_CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_dm_addr(in_dm_addr), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_alu_res(s_out_alu_res),
    .out_store_data(s_out_store_data), .out_dm_addr(s_out_dm_addr),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_main = '0;
  int unsigned   cnt_m     = 0;
  int unsigned   cnt_s     = 0;

  task automatic model_edge();
    bit have  = (exp_q.size() > 0);
    bit room  = (exp_q.size() < 2) && !rst;
    if (rst) begin
      exp_q.delete();
      last_main = '0;
      cnt_m     = 0;
      cnt_s     = 0;
    end else begin
      if (have && !out_ready) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt_s < 7) cnt_s++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (have && out_ready) void'(exp_q.pop_front());
        if (in_valid && room)
          exp_q.push_back({in_ctrl, in_alu_res, in_store_data, in_dm_addr});
      end
      if (exp_q.size() > 0) last_main = exp_q[0];
    end
  endtask

  task automatic model_compare();
    logic [EW-1:0] e;
    logic          ev;
    logic [3:0]    ec;
    ev = (exp_q.size() > 0);
    e  = last_main;
    ec = e[EW-1 -: 4];
    if (!ev) ec = ec & 4'b1110;
    chk("m_out_valid", 128'(out_valid), 128'(ev));
    chk("m_in_ready", 128'(in_ready), 128'((exp_q.size() < 2) && !rst));
    chk("m_out_ctrl", 128'(out_ctrl), 128'(ec));
    chk("m_out_alu_res", 128'(out_alu_res), 128'(e[79:48]));
    chk("m_out_store_data", 128'(out_store_data), 128'(e[47:16]));
    chk("m_out_dm_addr", 128'(out_dm_addr), 128'(e[15:0]));
    chk("m_stall_cnt", 128'(stall_cnt), 128'(cnt_m));
    chk("m_small_stall_cnt", 128'(s_stall_cnt), 128'(cnt_s));
  endtask

  initial begin
    @(posedge clk);
    model_edge();
    forever begin
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_edge();
    end
  end

  // ---------------- driver / directed scenarios ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_alu_res = '0;
    in_store_data = '0; in_dm_addr = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset values
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_alu", 128'(out_alu_res), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", 128'(in_ready), 128'(1));

    // Stream 1..8 at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_alu_res = 32'(k);
      step();
      @(negedge clk);
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_alu", 128'(out_alu_res), 128'(k));
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("stream_drained", 128'(out_valid), 128'(0));
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // Back-pressure: one extra accept into skid, then in_ready drops
    out_ready = 1'b0; in_valid = 1'b1; in_alu_res = 32'hA;
    step();
    @(negedge clk);
    chk("bp_a_out", 128'(out_alu_res), 128'(32'hA));
    chk("bp_ready_after_a", 128'(in_ready), 128'(1));
    in_alu_res = 32'hB;
    step();
    @(negedge clk);
    chk("bp_ready_after_b", 128'(in_ready), 128'(0));
    chk("bp_still_a", 128'(out_alu_res), 128'(32'hA));
    in_valid = 1'b0;
    step();
    @(negedge clk);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_b_out", 128'(out_alu_res), 128'(32'hB));
    chk("bp_b_valid", 128'(out_valid), 128'(1));
    step();
    @(negedge clk);
    chk("bp_empty", 128'(out_valid), 128'(0));
    chk("bp_stall", 128'(stall_cnt), 128'(2));

    // Flush while full with a store in flight
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'b0001; in_alu_res = 32'h21;
    step();
    in_alu_res = 32'h22;
    step();
    @(negedge clk);
    chk("fl_full", 128'(in_ready), 128'(0));
    flush = 1'b1; in_alu_res = 32'h23;
    step();
    @(negedge clk);
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(4'b0000));
    chk("fl_in_ready", 128'(in_ready), 128'(1));
    chk("fl_stall_kept", 128'(stall_cnt), 128'(4));
    flush = 1'b0; out_ready = 1'b1; in_ctrl = 4'b0000; in_alu_res = 32'h24;
    step();
    @(negedge clk);
    chk("fl_next_valid", 128'(out_valid), 128'(1));
    chk("fl_next_alu", 128'(out_alu_res), 128'(32'h24));

    // Bubble masks write enable of stale control
    in_ctrl = 4'b1111; in_alu_res = 32'h30;
    step();
    @(negedge clk);
    chk("bub_live_ctrl", 128'(out_ctrl), 128'(4'b1111));
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("bub_ctrl", 128'(out_ctrl), 128'(4'b1110));
    chk("bub_valid", 128'(out_valid), 128'(0));

    // Saturation of the narrow counter
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'b0001; in_alu_res = 32'h40;
    in_store_data = 32'h1234; in_dm_addr = 16'h0055;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("sat_small", 128'(s_stall_cnt), 128'(7));
    chk("sat_wide", 128'(stall_cnt), 128'(10));
    step();
    @(negedge clk);
    chk("sat_small_hold", 128'(s_stall_cnt), 128'(7));
    chk("sat_wide_next", 128'(stall_cnt), 128'(11));

    // Reset while holding two entries
    in_valid = 1'b1; in_alu_res = 32'h41;
    step();
    @(negedge clk);
    chk("r2_full", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("r2_valid", 128'(out_valid), 128'(0));
    chk("r2_alu", 128'(out_alu_res), 128'(0));
    chk("r2_store", 128'(out_store_data), 128'(0));
    chk("r2_addr", 128'(out_dm_addr), 128'(0));
    chk("r2_ctrl", 128'(out_ctrl), 128'(0));
    chk("r2_stall", 128'(stall_cnt), 128'(0));
    chk("r2_in_ready", 128'(in_ready), 128'(0));
    step();
    @(negedge clk);
    chk("r2_in_ready_hold", 128'(in_ready), 128'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("r2_in_ready_release", 128'(in_ready), 128'(1));

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      in_ctrl       = 4'($urandom_range(0, 15));
      in_alu_res    = $urandom;
      in_store_data = $urandom;
      in_dm_addr    = 16'($urandom_range(0, 65535));
      if (i % 500 == 250) out_ready = 1'b0;
      step();
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
